// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register numbers, ExcCode values, SR/Cause bit
// positions, the event type used by the commit-stage arbiter, and the EPC helper.
package cp0_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int SR_IE        = 0;
  localparam int SR_EXL       = 1;
  localparam int SR_IM_LO     = 10;
  localparam int SR_IM_HI     = 15;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD     = 31;

  // What the commit stage does this cycle, highest-priority winner only.
  typedef enum logic [1:0] {
    EV_NONE,
    EV_IRQ,
    EV_EXC,
    EV_ERET
  } cp0_event_e;

  // A victim in a delay slot restarts at its branch, one word earlier.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/cp0_irq_ctrl_if.sv
// Pipeline <-> CP0 bundle: mtc0/mfc0 port, interrupt lines, commit-stage
// victim description and the fetch redirect. The pipeline is the master.
interface cp0_irq_ctrl_if #(
  parameter int NUM_HW_IRQ = 6
);
  logic                  we;
  logic [4:0]            wnum;
  logic [31:0]           wdata;
  logic [4:0]            rnum;
  logic [31:0]           rdata;
  logic [NUM_HW_IRQ-1:0] hw_irq;
  logic                  victim_valid;
  logic [31:0]           victim_pc;
  logic                  victim_bd;
  logic                  exc_valid;
  logic [4:0]            exc_code;
  logic                  eret;
  logic                  irq_req;
  logic                  exl;
  logic                  jump;
  logic [31:0]           jump_addr;

  modport master (
    output we, wnum, wdata, rnum, hw_irq,
    output victim_valid, victim_pc, victim_bd, exc_valid, exc_code, eret,
    input  rdata, irq_req, exl, jump, jump_addr
  );

  modport slave (
    input  we, wnum, wdata, rnum, hw_irq,
    input  victim_valid, victim_pc, victim_bd, exc_valid, exc_code, eret,
    output rdata, irq_req, exl, jump, jump_addr
  );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer for CP0. Only built when CP0_TIMER_EN is defined, so the
// default build carries no stray top-level module.
`ifdef CP0_TIMER_EN
module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        pending_o
);
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        pending_q, pending_d;

  // Free-running count; a load replaces the increment for that one cycle.
  // A Compare write acknowledges the timer and wins over a same-cycle match.
  always_comb begin
    count_d   = count_we_i ? wdata_i : (count_q + 32'd1);
    compare_d = compare_we_i ? wdata_i : compare_q;
    pending_d = compare_we_i ? 1'b0 : (pending_q | (count_q == compare_q));
  end

  // Timer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      compare_q <= '0;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      pending_q <= pending_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign pending_o = pending_q;
endmodule
`endif

// File: rtl/cp0_irq_ctrl.sv
// Coprocessor 0 for the pipelined MIPS core: SR, Cause, EPC, PrId, interrupt /
// exception / ERET arbitration at commit, and mtc0/mfc0 from execute.
// Optional Count/Compare timer (regs 9/11, ORed into IP7) under CP0_TIMER_EN.
module cp0_irq_ctrl
  import cp0_pkg::*;
#(
  parameter int          NUM_HW_IRQ   = 6,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID_VALUE   = 32'hDEADBEEF
) (
  input logic            clk,
  input logic            reset,
  cp0_irq_ctrl_if.slave  bus
);
  logic [NUM_HW_IRQ-1:0] hw_q;
  logic [5:0]            im_q, im_d;
  logic                  exl_q, exl_d;
  logic                  ie_q, ie_d;
  logic                  bd_q, bd_d;
  logic [4:0]            exc_code_q, exc_code_d;
  logic [31:0]           epc_q, epc_d;

  logic [5:0]            ip;
  logic                  irq_req;
  cp0_event_e            ev;
  logic                  mtc0_go;

`ifdef CP0_TIMER_EN
  logic [31:0] tmr_count;
  logic [31:0] tmr_compare;
  logic        tmr_pending;

  cp0_timer u_timer (
    .clk          (clk),
    .reset        (reset),
    .count_we_i   (mtc0_go && (bus.wnum == CP0_COUNT)),
    .compare_we_i (mtc0_go && (bus.wnum == CP0_COMPARE)),
    .wdata_i      (bus.wdata),
    .count_o      (tmr_count),
    .compare_o    (tmr_compare),
    .pending_o    (tmr_pending)
  );
`endif

  // IP[2..] vector: registered lines, unused slots zero, timer folded into IP7.
  always_comb begin
    ip = '0;
    for (int k = 0; k < NUM_HW_IRQ; k++) ip[k] = hw_q[k];
`ifdef CP0_TIMER_EN
    ip[5] = ip[5] | tmr_pending;
`endif
  end

  assign irq_req = !reset && ie_q && !exl_q && |(ip & im_q);

  // Pick this cycle's single commit event; reset suppresses everything.
  always_comb begin
    ev = EV_NONE;
    if (!reset) begin
      if (irq_req && bus.victim_valid) ev = EV_IRQ;
      else if (bus.exc_valid)          ev = EV_EXC;
      else if (bus.eret)               ev = EV_ERET;
    end
  end

  // An mtc0 only lands in a cycle with no commit event.
  assign mtc0_go = !reset && bus.we && (ev == EV_NONE);

  // Next-state for SR/Cause/EPC from the winning event or the mtc0.
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    case (ev)
      EV_IRQ, EV_EXC: begin
        exc_code_d = (ev == EV_IRQ) ? EXC_INT : bus.exc_code;
        epc_d      = epc_of(bus.victim_pc, bus.victim_bd);
        bd_d       = bus.victim_bd;
        exl_d      = 1'b1;
      end
      EV_ERET: exl_d = 1'b0;
      default: begin
        if (mtc0_go) begin
          case (bus.wnum)
            CP0_SR: begin
              im_d  = bus.wdata[SR_IM_HI:SR_IM_LO];
              exl_d = bus.wdata[SR_EXL];
              ie_d  = bus.wdata[SR_IE];
            end
            CP0_CAUSE: begin
              bd_d       = bus.wdata[CAUSE_BD];
              exc_code_d = bus.wdata[CAUSE_EXC_HI:CAUSE_EXC_LO];
            end
            CP0_EPC: epc_d = {bus.wdata[31:2], 2'b00};
            default: ;
          endcase
        end
      end
    endcase
  end

  // Architectural state and the interrupt-line synchroniser stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      hw_q       <= '0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else begin
      hw_q       <= bus.hw_irq;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  // mfc0 reads pre-edge state; unimplemented numbers read zero.
  always_comb begin
    bus.rdata = '0;
    case (bus.rnum)
      CP0_SR:    bus.rdata = {16'b0, im_q, 8'b0, exl_q, ie_q};
      CP0_CAUSE: bus.rdata = {bd_q, 15'b0, ip, 3'b0, exc_code_q, 2'b00};
      CP0_EPC:   bus.rdata = epc_q;
      CP0_PRID:  bus.rdata = PRID_VALUE;
`ifdef CP0_TIMER_EN
      CP0_COUNT:   bus.rdata = tmr_count;
      CP0_COMPARE: bus.rdata = tmr_compare;
`endif
      default:   bus.rdata = '0;
    endcase
  end

  assign bus.irq_req   = irq_req;
  assign bus.exl       = exl_q;
  assign bus.jump      = (ev != EV_NONE);
  assign bus.jump_addr = (ev == EV_ERET) ? epc_q :
                         ((ev == EV_IRQ) || (ev == EV_EXC)) ? HANDLER_ADDR : 32'h0;
endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Scoreboard bench for cp0_irq_ctrl: the stimulus process queues expected
// values; a negedge monitor pops and compares them, and checks every redirect.
module tb_cp0_irq_ctrl;
  import cp0_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cp0_irq_ctrl_if #(.NUM_HW_IRQ(6)) bus ();

  cp0_irq_ctrl #(
    .NUM_HW_IRQ   (6),
    .HANDLER_ADDR (32'h0000_4180),
    .PRID_VALUE   (32'hDEADBEEF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // kind: 0 rdata, 1 irq_req, 2 exl, 3 jump, 4 jump_addr
  typedef struct {
    string       name;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t chk_q[$];
  exp_t jmp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int kind, input logic [31:0] val);
    exp_t e;
    e.name = name; e.kind = kind; e.val = val;
    chk_q.push_back(e);
  endtask

  task automatic rd(input string name, input logic [4:0] num, input logic [31:0] val);
    bus.rnum = num;
    chk(name, 0, val);
  endtask

  task automatic jexp(input string name, input logic [31:0] addr);
    exp_t e;
    e.name = name; e.kind = 4; e.val = addr;
    jmp_q.push_back(e);
  endtask

  task automatic idle();
    bus.we           = 1'b0;
    bus.victim_valid = 1'b0;
    bus.victim_bd    = 1'b0;
    bus.exc_valid    = 1'b0;
    bus.eret         = 1'b0;
  endtask

  task automatic wr(input logic [4:0] num, input logic [31:0] data);
    bus.we    = 1'b1;
    bus.wnum  = num;
    bus.wdata = data;
  endtask

  // Monitor: drain queued expectations, then check redirect presence/target.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (chk_q.size() > 0) begin
      e = chk_q.pop_front();
      case (e.kind)
        0:       act = bus.rdata;
        1:       act = {31'b0, bus.irq_req};
        2:       act = {31'b0, bus.exl};
        3:       act = {31'b0, bus.jump};
        default: act = bus.jump_addr;
      endcase
      n_cmp++;
      if (act !== e.val) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
    if (jmp_q.size() > 0) begin
      e = jmp_q.pop_front();
      n_cmp++;
      if (bus.jump !== 1'b1 || bus.jump_addr !== e.val) begin
        n_bad++;
        $display("FAIL %s: got jump=%b addr=%h expected jump=1 addr=%h",
                 e.name, bus.jump, bus.jump_addr, e.val);
      end
    end else if (bus.jump !== 1'b0 && reset === 1'b0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_jump: got jump=%b addr=%h expected jump=0",
               bus.jump, bus.jump_addr);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    idle();
    bus.hw_irq    = '0;
    bus.rnum      = '0;
    bus.wnum      = '0;
    bus.wdata     = '0;
    bus.victim_pc = '0;
    bus.exc_code  = '0;
    tick(); tick();

    // Event presented while reset is held: no redirect, no state change.
    bus.victim_valid = 1'b1; bus.exc_valid = 1'b1;
    bus.victim_pc = 32'h5000; bus.exc_code = EXC_RI;
    chk("rst_jump", 3, 32'd0);
    chk("rst_jaddr", 4, 32'd0);
    tick();
    idle(); reset = 1'b0;

    // Reset state.
    rd("rst_cause", CP0_CAUSE, 32'h0);
    chk("rst_irq_req", 1, 32'd0);
    chk("rst_exl", 2, 32'd0);
    chk("rst_jump_idle", 3, 32'd0);
    tick();
`ifdef CP0_TIMER_EN
    wr(CP0_COMPARE, 32'hFFFF_FFFF);
`endif
    rd("rst_sr", CP0_SR, 32'h0);
    tick(); idle();
    rd("rst_epc", CP0_EPC, 32'h0);
    tick();
    rd("rst_prid", CP0_PRID, 32'hDEADBEEF);

    // Hardware interrupt on line 0.
    tick(); wr(CP0_SR, 32'h0000_0401);
    tick(); idle();
    rd("sr_write", CP0_SR, 32'h0000_0401);
    chk("irq_idle", 1, 32'd0);
    tick(); bus.hw_irq = 6'h01;
    chk("irq_latency0", 1, 32'd0);
    tick();
    chk("irq_latency1", 1, 32'd1);
    bus.victim_valid = 1'b1; bus.victim_pc = 32'h3010; bus.victim_bd = 1'b0;
    jexp("irq_jump", 32'h4180);
    tick(); idle(); bus.hw_irq = 6'h00;
    chk("irq_exl", 2, 32'd1);
    chk("irq_masked", 1, 32'd0);
    rd("irq_cause", CP0_CAUSE, 32'h0000_0400);
    tick();
    rd("irq_epc", CP0_EPC, 32'h3010);

    // Exception in a delay slot while EXL=1; same-cycle mtc0 EPC dropped.
    tick();
    bus.exc_valid = 1'b1; bus.exc_code = EXC_OV; bus.victim_valid = 1'b1;
    bus.victim_pc = 32'h3020; bus.victim_bd = 1'b1;
    wr(CP0_EPC, 32'h0000_1234);
    jexp("exc_jump", 32'h4180);
    tick(); idle();
    rd("exc_epc", CP0_EPC, 32'h301C);
    tick();
    rd("exc_cause", CP0_CAUSE, 32'h8000_0030);
    chk("exc_exl", 2, 32'd1);

    // EXL masks all enabled, asserted lines.
    tick(); wr(CP0_SR, 32'h0000_FC03);
    tick(); idle(); bus.hw_irq = 6'h3F;
    rd("mask_sr", CP0_SR, 32'h0000_FC03);
    tick(); bus.victim_valid = 1'b1; bus.victim_pc = 32'h3040;
    chk("mask_irq_req", 1, 32'd0);
    chk("mask_no_jump", 3, 32'd0);
    rd("mask_cause", CP0_CAUSE, 32'h8000_FC30);

    // ERET, then the pending interrupt is taken on the following cycle.
    tick(); bus.eret = 1'b1; bus.victim_valid = 1'b1; bus.victim_pc = 32'h3044;
    jexp("eret_jump", 32'h301C);
    tick(); bus.eret = 1'b0; bus.victim_valid = 1'b1;
    bus.victim_pc = 32'h3030; bus.victim_bd = 1'b0;
    chk("eret_exl", 2, 32'd0);
    chk("eret_irq_req", 1, 32'd1);
    jexp("eret_irq_jump", 32'h4180);
    tick(); idle();
    chk("eret_irq_exl", 2, 32'd1);
    rd("eret_irq_epc", CP0_EPC, 32'h3030);
    tick();
    rd("eret_irq_cause", CP0_CAUSE, 32'h0000_FC00);

    // Interrupt beats a same-cycle exception.
    tick(); bus.eret = 1'b1; bus.victim_valid = 1'b1;
    jexp("prio_eret_jump", 32'h3030);
    tick(); bus.eret = 1'b0;
    bus.exc_valid = 1'b1; bus.exc_code = EXC_ADEL; bus.victim_valid = 1'b1;
    bus.victim_pc = 32'h3040; bus.victim_bd = 1'b1;
    jexp("prio_irq_jump", 32'h4180);
    tick(); idle();
    rd("prio_cause", CP0_CAUSE, 32'h8000_FC00);
    bus.hw_irq = 6'h00;
    tick();
    rd("prio_epc", CP0_EPC, 32'h303C);

    // EPC low bits, unimplemented register, read-only PrId.
    tick(); wr(CP0_EPC, 32'h1235_5677);
    tick(); wr(5'd3, 32'hFFFF_FFFF);
    rd("epc_align", CP0_EPC, 32'h1235_5674);
    tick(); wr(CP0_PRID, 32'h0);
    rd("unimpl_reg", 5'd3, 32'h0);
    tick(); idle();
    rd("prid_ro", CP0_PRID, 32'hDEADBEEF);

    // ERET to the software-written EPC with nothing pending.
    tick(); bus.eret = 1'b1; bus.victim_valid = 1'b1;
    jexp("eret2_jump", 32'h1235_5674);
    tick(); idle();
    chk("eret2_exl", 2, 32'd0);
    chk("eret2_irq_req", 1, 32'd0);
    rd("eret2_cause", CP0_CAUSE, 32'h8000_0000);

    // Exception beats a same-cycle ERET.
    tick();
    bus.exc_valid = 1'b1; bus.eret = 1'b1; bus.exc_code = EXC_ADES;
    bus.victim_valid = 1'b1; bus.victim_pc = 32'h3050; bus.victim_bd = 1'b0;
    jexp("exc_eret_jump", 32'h4180);
    tick(); idle();
    rd("exc_eret_cause", CP0_CAUSE, 32'h0000_0014);
    chk("exc_eret_exl", 2, 32'd1);
    tick();
    rd("exc_eret_epc", CP0_EPC, 32'h3050);

`ifdef CP0_TIMER_EN
    // Compare=20, Count=10: IP7 appears once Count has passed 20.
    tick(); wr(CP0_COMPARE, 32'd20);
    tick(); wr(CP0_COUNT, 32'd10);
    tick(); idle();
    rd("tmr_count_load", CP0_COUNT, 32'd10);
    repeat (9) tick();
    tick();
    rd("tmr_not_yet", CP0_CAUSE, 32'h0000_0014);
    tick();
    rd("tmr_ip7", CP0_CAUSE, 32'h0000_8014);
    tick(); wr(CP0_COMPARE, 32'd99);
    tick(); idle();
    rd("tmr_clear", CP0_CAUSE, 32'h0000_0014);
    tick();
    rd("tmr_compare", CP0_COMPARE, 32'd99);
`else
    // Without the timer, 9/11 ignore writes and read zero.
    tick(); wr(CP0_COMPARE, 32'd20);
    tick(); wr(CP0_COUNT, 32'd10);
    tick(); idle();
    rd("no_tmr_compare", CP0_COMPARE, 32'h0);
    tick();
    rd("no_tmr_count", CP0_COUNT, 32'h0);
`endif

    tick(); tick();
    n_cmp++;
    if (chk_q.size() != 0 || jmp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", chk_q.size(), jmp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
